// File: rtl/mem_stage_sram_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_sram_pkg : shared FSM encoding and SRAM constants for mem_stage_sram
// Revision: 1.0
// ============================================================================
package mem_stage_sram_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_LOW  = 2'd1;
  localparam logic [1:0] STATE_HIGH = 2'd2;
  localparam logic [1:0] STATE_DONE = 2'd3;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW           = 16;

  // Word index relative to the SRAM window, modulo 2^32; byte offset bits drop out.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
    logic [31:0] diff;
    diff = byte_addr - base;
    return diff >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_sram_if.sv
`default_nettype none
// ============================================================================
// mem_stage_sram_if : pipeline request/response and SRAM bus of the memory stage
// Revision: 1.0
// ============================================================================
interface mem_stage_sram_if #(
  parameter int SRAM_AW = 18
);
  import mem_stage_sram_pkg::*;

  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [31:0]         ALU_result;
  logic [31:0]         Val_Rm;
  logic [31:0]         MEM_result;
  logic                ready;
  logic [SRAM_AW-1:0]  SRAM_ADDR;
  logic [SRAM_DW-1:0]  SRAM_DQ_in;
  logic [SRAM_DW-1:0]  SRAM_DQ_out;
  logic                SRAM_DQ_oe;
  logic                SRAM_WE_N;

  // master: upstream pipeline plus the SRAM device; slave: the memory stage
  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, SRAM_DQ_in,
    input  MEM_result, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, SRAM_DQ_in,
    output MEM_result, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_wait_counter.sv
`default_nettype none
// ============================================================================
// sram_wait_counter : counts 0..SRAM_WAIT-1 while enabled, flags the last cycle
// Revision: 1.0
// ============================================================================
module sram_wait_counter #(
  parameter int SRAM_WAIT = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      last
);

  localparam int          CW     = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SRAM_WAIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last = (count_q == C_LAST);

  // Wraps to zero after the last cycle so back-to-back phases restart cleanly.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
// mem_stage_sram : pipeline memory stage, 32-bit accesses as two 16-bit SRAM halves
// Revision: 1.0
// ============================================================================
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW   = 18
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_stage_sram_if.slave  bus
);

  logic [1:0]          state_q,      state_d;
  logic                op_wr_q,      op_wr_d;
  logic [SRAM_AW-2:0]  word_q,       word_d;
  logic [SRAM_DW-1:0]  hi_data_q,    hi_data_d;
  logic [31:0]         mem_result_q, mem_result_d;
  logic [SRAM_AW-1:0]  sram_addr_q,  sram_addr_d;
  logic [SRAM_DW-1:0]  dq_out_q,     dq_out_d;
  logic                dq_oe_q,      dq_oe_d;
  logic                we_n_q,       we_n_d;

  logic        req;
  logic        cnt_en;
  logic        cnt_last;
  logic [31:0] word_idx;

  assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign word_idx = word_index(bus.ALU_result, BASE_ADDR);
  assign cnt_en   = (state_q == STATE_LOW) || (state_q == STATE_HIGH);

  sram_wait_counter #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!cnt_en),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    word_d       = word_q;
    hi_data_d    = hi_data_q;
    mem_result_d = mem_result_q;
    sram_addr_d  = sram_addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    we_n_d       = we_n_q;

    case (state_q)
      STATE_IDLE: begin
        if (req) begin
          // A write wins when both enables are set.
          state_d     = STATE_LOW;
          op_wr_d     = bus.MEM_W_EN;
          word_d      = word_idx[SRAM_AW-2:0];
          hi_data_d   = bus.Val_Rm[31:16];
          sram_addr_d = {word_idx[SRAM_AW-2:0], 1'b0};
          dq_oe_d     = bus.MEM_W_EN;
          we_n_d      = !bus.MEM_W_EN;
          if (bus.MEM_W_EN) begin
            dq_out_d = bus.Val_Rm[15:0];
          end
        end
      end
      STATE_LOW: begin
        if (cnt_last) begin
          state_d     = STATE_HIGH;
          sram_addr_d = {word_q, 1'b1};
          if (op_wr_q) begin
            dq_out_d = hi_data_q;
          end else begin
            mem_result_d[15:0] = bus.SRAM_DQ_in;
          end
        end
      end
      STATE_HIGH: begin
        if (cnt_last) begin
          state_d = STATE_DONE;
          dq_oe_d = 1'b0;
          we_n_d  = 1'b1;
          if (!op_wr_q) begin
            mem_result_d[31:16] = bus.SRAM_DQ_in;
          end
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STATE_IDLE;
      op_wr_q      <= 1'b0;
      word_q       <= '0;
      hi_data_q    <= '0;
      mem_result_q <= '0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_wr_q      <= op_wr_d;
      word_q       <= word_d;
      hi_data_q    <= hi_data_d;
      mem_result_q <= mem_result_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
    end
  end

  assign bus.ready       = (state_q == STATE_DONE) || ((state_q == STATE_IDLE) && !req);
  assign bus.MEM_result  = mem_result_q;
  assign bus.SRAM_ADDR   = sram_addr_q;
  assign bus.SRAM_DQ_out = dq_out_q;
  assign bus.SRAM_DQ_oe  = dq_oe_q;
  assign bus.SRAM_WE_N   = we_n_q;

endmodule
`default_nettype wire
